uart_tx_fifo: RTL

- Byte buffer and issue controller directly upstream of the UART transmitter.
- Accepts bytes from firmware or peripheral logic at any rate.
- Stores them in a power-of-two FIFO.
- Hands them one at a time to the transmitter using its data/enable/busy handshake, so producers never poll transmitter busy.
- Sits between the bus-side UART register and the uart_tx instance.

---
 rtl/uart_pkg.sv | 7 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_tx_fifo.sv | 81 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and issue-controller state encoding for the UART TX path.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int HS_TIMEOUT = 4;
  localparam int HS_CNT_W = $clog2(HS_TIMEOUT);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with wrap-bit pointers and registered full/empty/level.
module sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic          empty_nx,
  output logic [AW:0]   level
);
  logic [DW-1:0] ram [2**AW];
  logic [AW:0] wr_ptr, rd_ptr, wr_nx, rd_nx, level_nx;
  logic push_ok, pop_ok;
  always_comb begin
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wr_nx = wr_ptr + {{AW{1'b0}}, push_ok};
    rd_nx = rd_ptr + {{AW{1'b0}}, pop_ok};
    level_nx = wr_nx - rd_nx;
    empty_nx = level_nx == '0;
  end
  assign pop_data = ram[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push_ok) ram[wr_ptr[AW-1:0]] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= wr_nx;
      rd_ptr <= rd_nx;
      level <= level_nx;
      full <= level_nx[AW];
      empty <= empty_nx;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers bytes and issues them to uart_tx via data/enable/busy handshake.
// Optional saturating drop counter when UART_TX_FIFO_OVF_CNT_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                wr_en_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic [DATA_W-1:0]   tx_data_o,
  output logic                tx_en_o,
  input  logic                tx_busy_i,
  output logic                idle_o
`ifdef UART_TX_FIFO_OVF_CNT_EN
  ,
  input  logic                ovf_clr_i,
  output logic [7:0]          ovf_cnt_o
`endif
);
  tx_state_e state;
  logic [HS_CNT_W-1:0] cnt;
  logic [DATA_W-1:0] head;
  logic pop, empty_nx;
  assign pop = state == S_IDLE && !empty_o && !tx_busy_i;
  sync_fifo #(.AW(DEPTH_LOG2), .DW(DATA_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(wr_en_i),
    .push_data(wr_data_i),
    .pop(pop),
    .pop_data(head),
    .full(full_o),
    .empty(empty_o),
    .empty_nx(empty_nx),
    .level(level_o)
  );
  // idle_o looks at next-state values so it rises on the same edge the FSM re-enters S_IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      tx_en_o <= 1'b0;
      tx_data_o <= '0;
      idle_o <= 1'b1;
    end else begin
      tx_en_o <= 1'b0;
      idle_o <= 1'b0;
      case (state)
        S_IDLE:
          if (pop) begin
            state <= S_WAIT_BUSY;
            tx_en_o <= 1'b1;
            tx_data_o <= head;
            cnt <= '0;
          end else idle_o <= empty_nx;
        S_WAIT_BUSY:
          if (tx_busy_i) state <= S_WAIT_DONE;
          else if (cnt == HS_CNT_W'(HS_TIMEOUT - 1)) begin
            state <= S_IDLE;
            idle_o <= empty_nx;
          end else cnt <= cnt + 1'b1;
        S_WAIT_DONE:
          if (!tx_busy_i) begin
            state <= S_IDLE;
            idle_o <= empty_nx;
          end
        default: state <= S_IDLE;
      endcase
    end
`ifdef UART_TX_FIFO_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_cnt_o <= '0;
    else ovf_cnt_o <= ovf_clr_i ? 8'd0 : (wr_en_i && full_o && ovf_cnt_o != 8'hFF) ? ovf_cnt_o + 8'd1 : ovf_cnt_o;
`endif
endmodule
